// File: rtl/fft_bfly_executor.sv
// fft_bfly_executor: 16-point radix-2 DIT butterfly engine.
// Pair read, twiddle multiply, add/sub, in-place write; 1 butterfly/cycle.
module fft_bfly_executor #(
    parameter int DW    = 16,
    parameter bit SCALE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    input  logic [3:0]      cmd_stage,
    input  logic [3:0]      cmd_addr,
    output logic            cmd_ready,
    output logic            mem_rd_en,
    output logic [3:0]      mem_rd_addr_a,
    output logic [3:0]      mem_rd_addr_b,
    input  logic [2*DW-1:0] mem_rd_data_a,
    input  logic [2*DW-1:0] mem_rd_data_b,
    output logic            mem_wr_en,
    output logic [3:0]      mem_wr_addr_a,
    output logic [3:0]      mem_wr_addr_b,
    output logic [2*DW-1:0] mem_wr_data_a,
    output logic [2*DW-1:0] mem_wr_data_b,
    output logic            stage_done,
    output logic            err_stage,
    output logic            busy
);
    localparam int PW = DW + 17;
    typedef logic signed [DW-1:0] cpt_t;

    logic            v0_q, v1_q, v2_q, v3_q;
    logic [3:0]      ta0_q, tb0_q, ta1_q, tb1_q;
    logic [3:0]      ta2_q, tb2_q, ta3_q, tb3_q;
    logic [2:0]      tw0_q, tw1_q;
    cpt_t            ar2_q, ai2_q, pr2_q, pi2_q;
    logic [2*DW-1:0] wa3_q, wb3_q;
    logic [3:0]      cnt_q, cnt_d, cur_q, cur_d;
    logic            done_q, done_d, err_q, err_d;

    logic            stage_ok, accept, real_bf, new_stg;
    logic [1:0]      s;
    logic [3:0]      k, h, j, top_d, bot_d;
    logic [2:0]      tw_d;

    cpt_t                 br, bi, ar, ai, pr_d, pi_d;
    logic signed [15:0]   wr, wi;
    logic signed [PW-1:0] pr_f, pi_f;
    logic signed [DW:0]   sar, sai, sbr, sbi;
    logic [2*DW-1:0]      wa_d, wb_d;

    function automatic logic [31:0] tw_rom(input logic [2:0] t);
        logic [31:0] w;
        w = '0;
        unique case (t)
            3'd0: w = {16'sd32767, 16'sd0};
            3'd1: w = {16'sd30274, -16'sd12540};
            3'd2: w = {16'sd23170, -16'sd23170};
            3'd3: w = {16'sd12540, -16'sd30274};
            3'd4: w = {16'sd0, -16'sd32767};
            3'd5: w = {-16'sd12540, -16'sd30274};
            3'd6: w = {-16'sd23170, -16'sd23170};
            3'd7: w = {-16'sd30274, -16'sd12540};
        endcase
        return w;
    endfunction

    function automatic cpt_t scl(input logic signed [DW:0] x);
        return SCALE ? DW'(x >>> 1) : DW'(x);
    endfunction

    // A stage switch must wait for the old stage's writes to land.
    assign busy      = v0_q | v1_q | v2_q | v3_q;
    assign cmd_ready = ~reset & ~(busy & (cmd_stage != cur_q));
    assign accept    = cmd_valid & cmd_ready;
    assign stage_ok  = ~|cmd_stage[3:2];
    assign real_bf   = accept & stage_ok & ~cmd_addr[3];
    assign new_stg   = accept & stage_ok & (cmd_stage != cur_q);
    assign err_d     = accept & ~stage_ok;
    assign cur_d     = new_stg ? cmd_stage : cur_q;

    assign s     = cmd_stage[1:0];
    assign k     = {1'b0, cmd_addr[2:0]};
    assign h     = 4'd1 << s;
    assign j     = k & (h - 4'd1);
    assign top_d = ((k >> s) << ({1'b0, s} + 3'd1)) | j;
    assign bot_d = top_d + h;
    assign tw_d  = 3'(j << (2'd3 - s));

    assign {br, bi} = mem_rd_data_b;
    assign {ar, ai} = mem_rd_data_a;
    assign {wr, wi} = tw_rom(tw1_q);

    assign pr_f = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
    assign pi_f = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
    assign pr_d = DW'(pr_f >>> 15);
    assign pi_d = DW'(pi_f >>> 15);

    assign sar  = (DW+1)'(ar2_q) + (DW+1)'(pr2_q);
    assign sai  = (DW+1)'(ai2_q) + (DW+1)'(pi2_q);
    assign sbr  = (DW+1)'(ar2_q) - (DW+1)'(pr2_q);
    assign sbi  = (DW+1)'(ai2_q) - (DW+1)'(pi2_q);
    assign wa_d = {scl(sar), scl(sai)};
    assign wb_d = {scl(sbr), scl(sbi)};

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (v2_q) begin
            if (cnt_q == 4'd7) begin
                cnt_d  = 4'd0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (new_stg) begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            ta0_q  <= '0;
            tb0_q  <= '0;
            ta1_q  <= '0;
            tb1_q  <= '0;
            ta2_q  <= '0;
            tb2_q  <= '0;
            ta3_q  <= '0;
            tb3_q  <= '0;
            tw0_q  <= '0;
            tw1_q  <= '0;
            ar2_q  <= '0;
            ai2_q  <= '0;
            pr2_q  <= '0;
            pi2_q  <= '0;
            wa3_q  <= '0;
            wb3_q  <= '0;
            cnt_q  <= '0;
            cur_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            v0_q <= real_bf;
            if (real_bf) begin
                ta0_q <= top_d;
                tb0_q <= bot_d;
                tw0_q <= tw_d;
            end
            v1_q <= v0_q;
            if (v0_q) begin
                ta1_q <= ta0_q;
                tb1_q <= tb0_q;
                tw1_q <= tw0_q;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                ta2_q <= ta1_q;
                tb2_q <= tb1_q;
                ar2_q <= ar;
                ai2_q <= ai;
                pr2_q <= pr_d;
                pi2_q <= pi_d;
            end
            v3_q <= v2_q;
            if (v2_q) begin
                ta3_q <= ta2_q;
                tb3_q <= tb2_q;
                wa3_q <= wa_d;
                wb3_q <= wb_d;
            end
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign mem_rd_en     = v0_q;
    assign mem_rd_addr_a = ta0_q;
    assign mem_rd_addr_b = tb0_q;
    assign mem_wr_en     = v3_q;
    assign mem_wr_addr_a = ta3_q;
    assign mem_wr_addr_b = tb3_q;
    assign mem_wr_data_a = wa3_q;
    assign mem_wr_data_b = wb3_q;
    assign stage_done    = done_q;
    assign err_stage     = err_q;

endmodule

// File: tb/tb_fft_bfly_executor.sv
// Directed bench for fft_bfly_executor with a behavioural dual-port
// memory (1-cycle read latency) and hand-computed butterfly results.
module tb_fft_bfly_executor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_stage = '0;
    logic [3:0]  cmd_addr = '0;
    logic        cmd_ready;
    logic        mem_rd_en;
    logic [3:0]  mem_rd_addr_a, mem_rd_addr_b;
    logic [31:0] rda = '0, rdb = '0;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_addr_a, mem_wr_addr_b;
    logic [31:0] mem_wr_data_a, mem_wr_data_b;
    logic        stage_done, err_stage, busy;

    logic [31:0] mem [16];
    logic [31:0] init_mem [16];
    logic        ld_all = 1'b0;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    fft_bfly_executor #(.DW(16), .SCALE(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_stage    (cmd_stage),
        .cmd_addr     (cmd_addr),
        .cmd_ready    (cmd_ready),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr_a(mem_rd_addr_a),
        .mem_rd_addr_b(mem_rd_addr_b),
        .mem_rd_data_a(rda),
        .mem_rd_data_b(rdb),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr_a(mem_wr_addr_a),
        .mem_wr_addr_b(mem_wr_addr_b),
        .mem_wr_data_a(mem_wr_data_a),
        .mem_wr_data_b(mem_wr_data_b),
        .stage_done   (stage_done),
        .err_stage    (err_stage),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_all)
            for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
        if (mem_rd_en) begin
            rda <= mem[mem_rd_addr_a];
            rdb <= mem[mem_rd_addr_b];
        end
        if (mem_wr_en) begin
            mem[mem_wr_addr_a] <= mem_wr_data_a;
            mem[mem_wr_addr_b] <= mem_wr_data_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(busy), 32'(0));
    endtask

    int top3 [8] = '{0, 1, 4, 5, 8, 9, 12, 13};
    int kk, w, nwr, done_at;
    logic seen, sawwr;

    initial begin
        for (int i = 0; i < 16; i++) init_mem[i] = '0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'(0));
        chk("rst_rd_en", 32'(mem_rd_en), 32'(0));
        chk("rst_wr_en", 32'(mem_wr_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(stage_done), 32'(0));
        chk("rst_err", 32'(err_stage), 32'(0));
        chk("rst_wdata", mem_wr_data_a, 32'(0));
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        init_mem[0]  = pk(16384, 0);
        init_mem[1]  = pk(16384, 0);
        init_mem[5]  = pk(1000, -2000);
        init_mem[13] = pk(16384, 0);
        ld_all = 1'b1;
        @(negedge clk);
        ld_all = 1'b0;

        // T1: stage 0, k=0
        cmd_valid = 1'b1; cmd_stage = 4'd0; cmd_addr = 4'd0;
        #1 chk("t1_ready", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t1_rd_en", 32'(mem_rd_en), 32'(1));
        chk("t1_rd_a", 32'(mem_rd_addr_a), 32'(0));
        chk("t1_rd_b", 32'(mem_rd_addr_b), 32'(1));
        chk("t1_busy", 32'(busy), 32'(1));
        @(negedge clk);
        chk("t1_rd_once", 32'(mem_rd_en), 32'(0));
        chk("t1_wr_e1", 32'(mem_wr_en), 32'(0));
        @(negedge clk);
        chk("t1_wr_e2", 32'(mem_wr_en), 32'(0));
        @(negedge clk);
        chk("t1_wr_en", 32'(mem_wr_en), 32'(1));
        chk("t1_wr_a", 32'(mem_wr_addr_a), 32'(0));
        chk("t1_wr_b", 32'(mem_wr_addr_b), 32'(1));
        chk("t1_da", mem_wr_data_a, pk(16383, 0));
        chk("t1_db", mem_wr_data_b, pk(0, 0));
        chk("t1_done", 32'(stage_done), 32'(0));
        @(negedge clk);
        chk("t1_wr_once", 32'(mem_wr_en), 32'(0));
        chk("t1_idle", 32'(busy), 32'(0));

        // T2: stage 3, k=5, twiddle 5
        cmd_valid = 1'b1; cmd_stage = 4'd3; cmd_addr = 4'd5;
        #1 chk("t2_ready", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t2_rd_a", 32'(mem_rd_addr_a), 32'(5));
        chk("t2_rd_b", 32'(mem_rd_addr_b), 32'(13));
        repeat (3) @(negedge clk);
        chk("t2_wr_en", 32'(mem_wr_en), 32'(1));
        chk("t2_wr_a", 32'(mem_wr_addr_a), 32'(5));
        chk("t2_wr_b", 32'(mem_wr_addr_b), 32'(13));
        chk("t2_da", mem_wr_data_a, pk(-2635, -8569));
        chk("t2_db", mem_wr_data_b, pk(3635, 6568));
        @(negedge clk);
        chk("t2_idle", 32'(busy), 32'(0));

        // T3: stage 1, k=0..7 back to back
        for (int i = 0; i < 16; i++) init_mem[i] = pk(16384, 0);
        ld_all = 1'b1;
        @(negedge clk);
        ld_all = 1'b0;
        for (int n = 0; n < 11; n++) begin
            if (n < 8) begin
                cmd_valid = 1'b1; cmd_stage = 4'd1; cmd_addr = 4'(n);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            if (n < 8) begin
                chk("t3_rd_en", 32'(mem_rd_en), 32'(1));
                chk("t3_rd_a", 32'(mem_rd_addr_a), 32'(top3[n]));
                chk("t3_rd_b", 32'(mem_rd_addr_b), 32'(top3[n] + 2));
            end else begin
                chk("t3_rd_off", 32'(mem_rd_en), 32'(0));
            end
            if (n >= 3) begin
                kk = n - 3;
                chk("t3_wr_en", 32'(mem_wr_en), 32'(1));
                chk("t3_wr_a", 32'(mem_wr_addr_a), 32'(top3[kk]));
                chk("t3_wr_b", 32'(mem_wr_addr_b), 32'(top3[kk] + 2));
                chk("t3_da", mem_wr_data_a,
                    (kk % 2 == 0) ? pk(16383, 0) : pk(8192, -8192));
                chk("t3_db", mem_wr_data_b,
                    (kk % 2 == 0) ? pk(0, 0) : pk(8192, 8192));
                chk("t3_done", 32'(stage_done), 32'(kk == 7));
            end else begin
                chk("t3_wr_early", 32'(mem_wr_en), 32'(0));
            end
        end
        @(negedge clk);
        chk("t3_idle", 32'(busy), 32'(0));
        chk("t3_done_once", 32'(stage_done), 32'(0));

        // T4: stage switch waits for the drain
        cmd_valid = 1'b1; cmd_stage = 4'd1; cmd_addr = 4'd7;
        @(negedge clk);
        cmd_stage = 4'd2; cmd_addr = 4'd0;
        #1 chk("t4_blocked", 32'(cmd_ready), 32'(0));
        w = 0;
        sawwr = 1'b0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
            if (mem_wr_en && mem_wr_addr_a == 4'd13) sawwr = 1'b1;
        end
        chk("t4_wait", 32'(w), 32'(4));
        chk("t4_wr_first", 32'(sawwr), 32'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t4_rd_en", 32'(mem_rd_en), 32'(1));
        chk("t4_rd_a", 32'(mem_rd_addr_a), 32'(0));
        chk("t4_rd_b", 32'(mem_rd_addr_b), 32'(4));
        wait_idle("t4_idle");

        // T5: bad stage and out-of-range butterfly
        cmd_valid = 1'b1; cmd_stage = 4'd4; cmd_addr = 4'd0;
        #1 chk("t5_ready", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        chk("t5_err", 32'(err_stage), 32'(1));
        chk("t5_rd_bad", 32'(mem_rd_en), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        cmd_stage = 4'd2; cmd_addr = 4'd9;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t5_err_k9", 32'(err_stage), 32'(0));
        chk("t5_rd_k9", 32'(mem_rd_en), 32'(0));
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_wr_en || mem_rd_en || err_stage) seen = 1'b1;
        end
        chk("t5_quiet", 32'(seen), 32'(0));

        // T6: reset two cycles after accept
        cmd_valid = 1'b1; cmd_stage = 4'd2; cmd_addr = 4'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t6_rd_en", 32'(mem_rd_en), 32'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_ready", 32'(cmd_ready), 32'(0));
        chk("t6_wr_en", 32'(mem_wr_en), 32'(0));
        chk("t6_waddr", 32'(mem_wr_addr_a), 32'(0));
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_wr_en || stage_done) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_wr_en || stage_done || busy) seen = 1'b1;
        end
        chk("t6_no_wr", 32'(seen), 32'(0));

        // retire counter restarts from zero after reset
        nwr = 0;
        done_at = 0;
        for (int n = 0; n < 12; n++) begin
            if (n < 8) begin
                cmd_valid = 1'b1; cmd_stage = 4'd0; cmd_addr = 4'(n);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            if (mem_wr_en) begin
                nwr++;
                if (stage_done) done_at = nwr;
            end
        end
        chk("t6_nwr", 32'(nwr), 32'(8));
        chk("t6_done_at", 32'(done_at), 32'(8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
